// File: rtl/mcs4_pkg.sv
// mcs4_pkg -- shared types and constants for the MCS-4 bus master.
//
// Contents:
//   subcycle_e      the eight bus subcycles of one instruction cycle,
//                   A1 A2 A3 M1 M2 X1 X2 X3, in bus order
//   TICKS_PER_SUB   prescaled ticks per subcycle
//   SUBS_PER_CYCLE  subcycles per instruction cycle
//   NIBBLE_W, ADDR_W, INSTR_W, TICK_W  bus / address / opcode / tick widths
//   next_sub()      subcycle successor with the X3 -> A1 wrap
package mcs4_pkg;

    localparam int TICKS_PER_SUB  = 4;
    localparam int SUBS_PER_CYCLE = 8;
    localparam int NIBBLE_W       = 4;
    localparam int ADDR_W         = 12;
    localparam int INSTR_W        = 8;
    localparam int TICK_W         = 2;

    typedef enum logic [2:0] {
        SUB_A1 = 3'd0,
        SUB_A2 = 3'd1,
        SUB_A3 = 3'd2,
        SUB_M1 = 3'd3,
        SUB_M2 = 3'd4,
        SUB_X1 = 3'd5,
        SUB_X2 = 3'd6,
        SUB_X3 = 3'd7
    } subcycle_e;

    function automatic subcycle_e next_sub(input subcycle_e s);
        if (s == SUB_X3) begin
            return SUB_A1;
        end
        return subcycle_e'(s + 3'd1);
    endfunction

endpackage

// File: rtl/mcs4_bus_master_if.sv
// mcs4_bus_master_if -- the MCS-4 bus pins seen from the CPU side.
//
// Signals:
//   PHI1_o, PHI2_o  two-phase clock strobes
//   SYNC_o          high during X3, announces the next A1
//   D_o, D_oe_o     data bus value and output enable driven by the master
//   D_i             data bus value returned by ROM/RAM/IO devices
//   CM_ROM_o        ROM command line
//   CM_RAM_o        RAM bank command lines
// Modports:
//   master  the bus sequencer (drives strobes, commands and D_o)
//   slave   a device model / responder (drives D_i)
interface mcs4_bus_master_if;
    import mcs4_pkg::*;

    logic                PHI1_o;
    logic                PHI2_o;
    logic                SYNC_o;
    logic [NIBBLE_W-1:0] D_i;
    logic [NIBBLE_W-1:0] D_o;
    logic                D_oe_o;
    logic                CM_ROM_o;
    logic [NIBBLE_W-1:0] CM_RAM_o;

    modport master (
        output PHI1_o, PHI2_o, SYNC_o, D_o, D_oe_o, CM_ROM_o, CM_RAM_o,
        input  D_i
    );

    modport slave (
        input  PHI1_o, PHI2_o, SYNC_o, D_o, D_oe_o, CM_ROM_o, CM_RAM_o,
        output D_i
    );

endinterface

// File: rtl/mcs4_phase_gen.sv
// mcs4_phase_gen -- prescaler, tick counter and two-phase clock strobes.
//
// Parameters:
//   CLK_DIV      clk_i cycles per tick (>= 1)
// Ports:
//   clk_i        design clock
//   rst_ni       asynchronous active-low reset
//   tick_en_o    last clk of the current tick (tick advances on this edge)
//   tick_o       tick index 0..3 within the subcycle
//   sub_start_o  first clk of a subcycle (tick 0, prescaler 0)
//   sub_end_o    last clk of a subcycle (subcycle advances on this edge)
//   phi1_o       registered PHI1 strobe, high while tick 0 is on the bus
//   phi2_o       registered PHI2 strobe, high while tick 2 is on the bus
//
// The strobes are registered from the current tick, so they trail the
// internal counter by one clk. The sequencer registers every other bus
// output the same way, which keeps all pins aligned with each other.
module mcs4_phase_gen
    import mcs4_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    output logic              tick_en_o,
    output logic [TICK_W-1:0] tick_o,
    output logic              sub_start_o,
    output logic              sub_end_o,
    output logic              phi1_o,
    output logic              phi2_o
);

    // A one-bit prescaler is kept for CLK_DIV=1; it simply never leaves 0.
    localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SUB - 1);

    logic [DIV_W-1:0]  div_cnt_reg;
    logic [TICK_W-1:0] tick_reg;
    logic              phi1_reg;
    logic              phi2_reg;

    assign tick_en_o   = (div_cnt_reg == DIV_LAST);
    assign tick_o      = tick_reg;
    assign sub_start_o = (div_cnt_reg == '0) && (tick_reg == '0);
    assign sub_end_o   = tick_en_o && (tick_reg == TICK_LAST);
    assign phi1_o      = phi1_reg;
    assign phi2_o      = phi2_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_reg <= '0;
            tick_reg    <= '0;
            phi1_reg    <= 1'b0;
            phi2_reg    <= 1'b0;
        end else begin
            if (tick_en_o) begin
                div_cnt_reg <= '0;
                tick_reg    <= tick_reg + TICK_W'(1);
            end else begin
                div_cnt_reg <= div_cnt_reg + DIV_W'(1);
            end
            // PHI1 on tick 0 and PHI2 on tick 2 can never coincide.
            phi1_reg <= (tick_reg == TICK_W'(0));
            phi2_reg <= (tick_reg == TICK_W'(2));
        end
    end

endmodule

// File: rtl/mcs4_bus_master.sv
// mcs4_bus_master -- CPU-side sequencer for the MCS-4 multiplexed bus.
//
// Parameters:
//   CLK_DIV        clk_i cycles per tick (>= 1); 4 ticks per subcycle
// Ports:
//   clk_i, rst_ni  clock and asynchronous active-low reset
//   bus            bus pins (mcs4_bus_master_if.master)
//   addr_i         12-bit fetch address, latched at the first clk of A1
//   ram_bank_i     CM-RAM pattern, latched at the first clk of A3
//   cm_m2_i        raise CM lines in M2, sampled at the first clk of M2
//   instr_o        last fetched instruction {OPR, OPA}
//   instr_valid_o  one-clk pulse when instr_o updates
//   io_wr_i        X2 write request, sampled at the first clk of X2
//   io_wr_data_i   X2 write nibble, sampled with io_wr_i
//   io_rd_data_o   nibble read at the end of X2
//   io_rd_valid_o  one-clk pulse when io_rd_data_o updates
// Build option:
//   MCS4_IO_PHASE_EN  enables the X2 I/O write/read phase; when undefined
//                     X2 is idle and the io_* outputs stay 0.
//
// Timing model: sub_reg and the phase generator hold the internal state.
// Every bus output is a register loaded from the internal state, so the pins
// show each clk of the cycle one clk after the internal counters reach it.
// Out of reset the internal state is X3/tick 0 and all outputs are 0; the
// first edge then puts X3 on the pins, giving a full-length X3 before A1.
// Inputs sampled "at the first clk" of a subcycle are taken on the same edge
// that loads that clk onto the pins; D_i is sampled on the edge that closes
// the last pin-visible clk of M1/M2/X2.
module mcs4_bus_master
    import mcs4_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    mcs4_bus_master_if.master     bus,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [NIBBLE_W-1:0]   ram_bank_i,
    input  logic                  cm_m2_i,
    output logic [INSTR_W-1:0]    instr_o,
    output logic                  instr_valid_o,
    input  logic                  io_wr_i,
    input  logic [NIBBLE_W-1:0]   io_wr_data_i,
    output logic [NIBBLE_W-1:0]   io_rd_data_o,
    output logic                  io_rd_valid_o
);

    // ------------------------------------------------------------------
    // Phase generation
    // ------------------------------------------------------------------
    logic              tick_en;
    logic [TICK_W-1:0] tick;
    logic              sub_start;
    logic              sub_end;
    logic              phi1;
    logic              phi2;

    mcs4_phase_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_phase_gen (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .tick_en_o   (tick_en),
        .tick_o      (tick),
        .sub_start_o (sub_start),
        .sub_end_o   (sub_end),
        .phi1_o      (phi1),
        .phi2_o      (phi2)
    );

    // The sequencer only needs subcycle boundaries.
    logic unused_phase;
    assign unused_phase = ^{tick_en, tick};

    // ------------------------------------------------------------------
    // Subcycle state and input latches
    // ------------------------------------------------------------------
    subcycle_e           sub_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [NIBBLE_W-1:0] bank_reg;
    logic                cm_m2_reg;

    logic at_a1_start;
    logic at_a3_start;
    logic at_m2_start;

    assign at_a1_start = sub_start && (sub_reg == SUB_A1);
    assign at_a3_start = sub_start && (sub_reg == SUB_A3);
    assign at_m2_start = sub_start && (sub_reg == SUB_M2);

    // On the latching edge itself the live input is used; afterwards the
    // latched copy, so later input changes cannot reach the bus.
    logic [ADDR_W-1:0]   addr_cur;
    logic [NIBBLE_W-1:0] bank_cur;
    logic                cm_m2_cur;

    assign addr_cur  = at_a1_start ? addr_i     : addr_reg;
    assign bank_cur  = at_a3_start ? ram_bank_i : bank_reg;
    assign cm_m2_cur = at_m2_start ? cm_m2_i    : cm_m2_reg;

    logic [NIBBLE_W-1:0] addr_nib [3];
    for (genvar gi = 0; gi < 3; gi++) begin : g_addr_nib
        assign addr_nib[gi] = addr_cur[gi*NIBBLE_W +: NIBBLE_W];
    end

`ifdef MCS4_IO_PHASE_EN
    logic                at_x2_start;
    logic                io_wr_reg;
    logic [NIBBLE_W-1:0] io_wr_data_reg;
    logic                io_wr_cur;
    logic [NIBBLE_W-1:0] io_wr_data_cur;

    assign at_x2_start    = sub_start && (sub_reg == SUB_X2);
    assign io_wr_cur      = at_x2_start ? io_wr_i      : io_wr_reg;
    assign io_wr_data_cur = at_x2_start ? io_wr_data_i : io_wr_data_reg;
`else
    logic unused_io;
    assign unused_io = ^{io_wr_i, io_wr_data_i};
`endif

    // ------------------------------------------------------------------
    // Next values of the registered bus outputs
    // ------------------------------------------------------------------
    logic                sync_next;
    logic [NIBBLE_W-1:0] d_o_next;
    logic                d_oe_next;
    logic                cm_rom_next;
    logic [NIBBLE_W-1:0] cm_ram_next;

    always_comb begin
        sync_next   = 1'b0;
        d_o_next    = '0;
        d_oe_next   = 1'b0;
        cm_rom_next = 1'b0;
        cm_ram_next = '0;
        unique case (sub_reg)
            SUB_A1: begin
                d_o_next  = addr_nib[0];
                d_oe_next = 1'b1;
            end
            SUB_A2: begin
                d_o_next  = addr_nib[1];
                d_oe_next = 1'b1;
            end
            SUB_A3: begin
                d_o_next    = addr_nib[2];
                d_oe_next   = 1'b1;
                cm_rom_next = 1'b1;
                cm_ram_next = bank_cur;
            end
            SUB_M2: begin
                if (cm_m2_cur) begin
                    cm_rom_next = 1'b1;
                    cm_ram_next = bank_reg;
                end
            end
            SUB_X2: begin
`ifdef MCS4_IO_PHASE_EN
                if (io_wr_cur) begin
                    d_o_next  = io_wr_data_cur;
                    d_oe_next = 1'b1;
                end
`endif
            end
            SUB_X3: begin
                sync_next = 1'b1;
            end
            default: begin
                // M1, X1: bus released, no command lines
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, latches and output registers
    // ------------------------------------------------------------------
    logic                sync_reg;
    logic [NIBBLE_W-1:0] d_o_reg;
    logic                d_oe_reg;
    logic                cm_rom_reg;
    logic [NIBBLE_W-1:0] cm_ram_reg;
    logic [NIBBLE_W-1:0] opr_reg;
    logic                opr_smp_reg;
    logic                opa_smp_reg;
    logic [INSTR_W-1:0]  instr_reg;
    logic                instr_valid_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sub_reg         <= SUB_X3;
            addr_reg        <= '0;
            bank_reg        <= '0;
            cm_m2_reg       <= 1'b0;
            sync_reg        <= 1'b0;
            d_o_reg         <= '0;
            d_oe_reg        <= 1'b0;
            cm_rom_reg      <= 1'b0;
            cm_ram_reg      <= '0;
            opr_reg         <= '0;
            opr_smp_reg     <= 1'b0;
            opa_smp_reg     <= 1'b0;
            instr_reg       <= '0;
            instr_valid_reg <= 1'b0;
        end else begin
            if (sub_end) begin
                sub_reg <= next_sub(sub_reg);
            end
            if (at_a1_start) begin
                addr_reg <= addr_i;
            end
            if (at_a3_start) begin
                bank_reg <= ram_bank_i;
            end
            if (at_m2_start) begin
                cm_m2_reg <= cm_m2_i;
            end

            sync_reg   <= sync_next;
            d_o_reg    <= d_o_next;
            d_oe_reg   <= d_oe_next;
            cm_rom_reg <= cm_rom_next;
            cm_ram_reg <= cm_ram_next;

            // The sample strobes are delayed one clk so D_i is taken at the
            // end of the last clk that the pins show as M1 / M2.
            opr_smp_reg <= (sub_reg == SUB_M1) && sub_end;
            opa_smp_reg <= (sub_reg == SUB_M2) && sub_end;
            if (opr_smp_reg) begin
                opr_reg <= bus.D_i;
            end
            instr_valid_reg <= opa_smp_reg;
            if (opa_smp_reg) begin
                instr_reg <= {opr_reg, bus.D_i};
            end
        end
    end

`ifdef MCS4_IO_PHASE_EN
    logic                rd_smp_reg;
    logic [NIBBLE_W-1:0] io_rd_data_reg;
    logic                io_rd_valid_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            io_wr_reg       <= 1'b0;
            io_wr_data_reg  <= '0;
            rd_smp_reg      <= 1'b0;
            io_rd_data_reg  <= '0;
            io_rd_valid_reg <= 1'b0;
        end else begin
            if (at_x2_start) begin
                io_wr_reg      <= io_wr_i;
                io_wr_data_reg <= io_wr_data_i;
            end
            // A read happens only in an X2 that was not claimed for a write.
            rd_smp_reg      <= (sub_reg == SUB_X2) && sub_end && !io_wr_reg;
            io_rd_valid_reg <= rd_smp_reg;
            if (rd_smp_reg) begin
                io_rd_data_reg <= bus.D_i;
            end
        end
    end

    assign io_rd_data_o  = io_rd_data_reg;
    assign io_rd_valid_o = io_rd_valid_reg;
`else
    assign io_rd_data_o  = '0;
    assign io_rd_valid_o = 1'b0;
`endif

    assign bus.PHI1_o    = phi1;
    assign bus.PHI2_o    = phi2;
    assign bus.SYNC_o    = sync_reg;
    assign bus.D_o       = d_o_reg;
    assign bus.D_oe_o    = d_oe_reg;
    assign bus.CM_ROM_o  = cm_rom_reg;
    assign bus.CM_RAM_o  = cm_ram_reg;
    assign instr_o       = instr_reg;
    assign instr_valid_o = instr_valid_reg;

endmodule

// File: tb/tb_mcs4_bus_master.sv
// tb_mcs4_bus_master -- directed bench for mcs4_bus_master.
// Two instances share clock, reset and core-side inputs: u_dut1 with
// CLK_DIV=1 (functional tests) and u_dut2 with CLK_DIV=2 (strobe timing).
// ncount numbers the falling edges after reset release; outputs are sampled
// on falling edges. With CLK_DIV=1 the pin-visible subcycles are:
// X3 1-4, A1 5-8, A2 9-12, A3 13-16, M1 17-20, M2 21-24, X1 25-28,
// X2 29-32, X3 33-36, then the next cycle from 37 (period 32).
module tb_mcs4_bus_master;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [11:0] addr       = 12'h000;
    logic [3:0]  ram_bank   = 4'h0;
    logic        cm_m2      = 1'b0;
    logic        io_wr      = 1'b0;
    logic [3:0]  io_wr_data = 4'h0;

    logic [7:0] instr1, instr2;
    logic       iv1, iv2;
    logic [3:0] rd1, rd2;
    logic       rv1, rv2;

    mcs4_bus_master_if bus1 ();
    mcs4_bus_master_if bus2 ();

    mcs4_bus_master #(.CLK_DIV(1)) u_dut1 (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .bus           (bus1),
        .addr_i        (addr),
        .ram_bank_i    (ram_bank),
        .cm_m2_i       (cm_m2),
        .instr_o       (instr1),
        .instr_valid_o (iv1),
        .io_wr_i       (io_wr),
        .io_wr_data_i  (io_wr_data),
        .io_rd_data_o  (rd1),
        .io_rd_valid_o (rv1)
    );

    mcs4_bus_master #(.CLK_DIV(2)) u_dut2 (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .bus           (bus2),
        .addr_i        (addr),
        .ram_bank_i    (ram_bank),
        .cm_m2_i       (cm_m2),
        .instr_o       (instr2),
        .instr_valid_o (iv2),
        .io_wr_i       (io_wr),
        .io_wr_data_i  (io_wr_data),
        .io_rd_data_o  (rd2),
        .io_rd_valid_o (rv2)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int ncount   = 0;

    task automatic step();
        @(negedge clk);
        ncount++;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        ncount = 0;
    endtask

    task automatic test_reset();
        logic [26:0] o1, o2;
        rst_n = 1'b0;
        addr = 12'hFFF; ram_bank = 4'hF; cm_m2 = 1'b1; io_wr = 1'b1; io_wr_data = 4'hF;
        bus1.D_i = 4'hF; bus2.D_i = 4'hF;
        repeat (3) @(negedge clk);
        o1 = {bus1.PHI1_o, bus1.PHI2_o, bus1.SYNC_o, bus1.D_o, bus1.D_oe_o, bus1.CM_ROM_o,
              bus1.CM_RAM_o, instr1, iv1, rd1, rv1};
        o2 = {bus2.PHI1_o, bus2.PHI2_o, bus2.SYNC_o, bus2.D_o, bus2.D_oe_o, bus2.CM_ROM_o,
              bus2.CM_RAM_o, instr2, iv2, rd2, rv2};
        chk_cnt++;
        if (o1 !== 27'd0) $display("FAIL reset_outs_dut1 got %h expected 0", o1);
        else pass_cnt++;
        chk_cnt++;
        if (o2 !== 27'd0) $display("FAIL reset_outs_dut2 got %h expected 0", o2);
        else pass_cnt++;
        rst_n  = 1'b1;
        ncount = 0;
        step();
        chk_cnt++;
        if ({bus1.SYNC_o, bus1.PHI1_o, bus1.PHI2_o} !== 3'b110)
            $display("FAIL first_clk_x3 got %b expected 110", {bus1.SYNC_o, bus1.PHI1_o, bus1.PHI2_o});
        else pass_cnt++;
        $display("test_reset: done");
    endtask

    task automatic test_clkdiv2_timing();
        logic exp_sync, exp_p1, exp_p2;
        int   ph;
        addr = 12'hA5C; ram_bank = 4'h0; cm_m2 = 1'b0; io_wr = 1'b0;
        bus1.D_i = 4'h0; bus2.D_i = 4'h0;
        apply_reset();
        for (int k = 1; k <= 32; k++) begin
            step();
            ph       = (k - 1) % 8;
            exp_sync = (k <= 8);
            exp_p1   = (ph == 0) || (ph == 1);
            exp_p2   = (ph == 4) || (ph == 5);
            chk_cnt++;
            if (bus2.SYNC_o !== exp_sync) $display("FAIL div2_sync k=%0d got %b expected %b", k, bus2.SYNC_o, exp_sync);
            else pass_cnt++;
            chk_cnt++;
            if (bus2.PHI1_o !== exp_p1) $display("FAIL div2_phi1 k=%0d got %b expected %b", k, bus2.PHI1_o, exp_p1);
            else pass_cnt++;
            chk_cnt++;
            if (bus2.PHI2_o !== exp_p2) $display("FAIL div2_phi2 k=%0d got %b expected %b", k, bus2.PHI2_o, exp_p2);
            else pass_cnt++;
            if (k == 8) begin
                chk_cnt++;
                if (bus2.D_oe_o !== 1'b0) $display("FAIL div2_x3_oe got %b expected 0", bus2.D_oe_o);
                else pass_cnt++;
            end
            if (k == 9) begin
                chk_cnt++;
                if ({bus2.D_oe_o, bus2.D_o} !== 5'h1C) $display("FAIL div2_a1_start got %h expected 1c", {bus2.D_oe_o, bus2.D_o});
                else pass_cnt++;
            end
        end
        $display("test_clkdiv2_timing: done");
    endtask

    task automatic test_fetch();
        logic       exp_oe, exp_iv;
        logic [3:0] exp_d;
        addr = 12'hA5C; ram_bank = 4'h0; cm_m2 = 1'b0; io_wr = 1'b0;
        bus1.D_i = 4'h0;
        apply_reset();
        for (int k = 1; k <= 32; k++) begin
            step();
            exp_oe = (k >= 5) && (k <= 16);
            exp_d  = (k >= 5 && k <= 8) ? 4'hC : (k >= 9 && k <= 12) ? 4'h5 :
                     (k >= 13 && k <= 16) ? 4'hA : 4'h0;
            exp_iv = (k == 25);
            chk_cnt++;
            if (bus1.D_oe_o !== exp_oe) $display("FAIL fetch_oe k=%0d got %b expected %b", k, bus1.D_oe_o, exp_oe);
            else pass_cnt++;
            chk_cnt++;
            if (bus1.D_o !== exp_d) $display("FAIL fetch_d_o k=%0d got %h expected %h", k, bus1.D_o, exp_d);
            else pass_cnt++;
            chk_cnt++;
            if (iv1 !== exp_iv) $display("FAIL fetch_valid k=%0d got %b expected %b", k, iv1, exp_iv);
            else pass_cnt++;
            if (k == 25) begin
                chk_cnt++;
                if (instr1 !== 8'h3E) $display("FAIL fetch_instr got %h expected 3e", instr1);
                else pass_cnt++;
            end
            if (k == 6)  addr = 12'h123;   // must not affect this cycle
            if (k == 17) bus1.D_i = 4'h3;
            if (k == 21) bus1.D_i = 4'hE;
            if (k == 25) bus1.D_i = 4'h0;
        end
        $display("test_fetch: instr=%h", instr1);
    endtask

    task automatic test_cm_lines();
        logic       exp_rom;
        logic [3:0] exp_ram;
        addr = 12'h000; ram_bank = 4'h4; cm_m2 = 1'b0; io_wr = 1'b0;
        bus1.D_i = 4'h0;
        apply_reset();
        for (int k = 1; k <= 64; k++) begin
            step();
            exp_rom = (k >= 13 && k <= 16) || (k >= 45 && k <= 48) || (k >= 53 && k <= 56);
            exp_ram = exp_rom ? 4'h4 : 4'h0;
            chk_cnt++;
            if (bus1.CM_ROM_o !== exp_rom) $display("FAIL cm_rom k=%0d got %b expected %b", k, bus1.CM_ROM_o, exp_rom);
            else pass_cnt++;
            chk_cnt++;
            if (bus1.CM_RAM_o !== exp_ram) $display("FAIL cm_ram k=%0d got %h expected %h", k, bus1.CM_RAM_o, exp_ram);
            else pass_cnt++;
            if (k == 14) ram_bank = 4'hF;  // after the A3 latch
            if (k == 16) ram_bank = 4'h4;
            if (k == 22) cm_m2 = 1'b1;     // mid-M2 and X1: not a sample point
            if (k == 26) cm_m2 = 1'b0;
            if (k == 50) cm_m2 = 1'b1;     // seen at the start of cycle-1 M2
            if (k == 54) cm_m2 = 1'b0;
        end
        $display("test_cm_lines: done");
    endtask

    task automatic test_reset_mid_m1();
        logic [26:0] o1, o2;
        addr = 12'hA5C; ram_bank = 4'h4; cm_m2 = 1'b0; io_wr = 1'b0;
        bus1.D_i = 4'h3;
        apply_reset();
        for (int k = 1; k <= 17; k++) step();
        chk_cnt++;
        if (bus1.PHI1_o !== 1'b1) $display("FAIL m1_phi1_before got %b expected 1", bus1.PHI1_o);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        o1 = {bus1.PHI1_o, bus1.PHI2_o, bus1.SYNC_o, bus1.D_o, bus1.D_oe_o, bus1.CM_ROM_o,
              bus1.CM_RAM_o, instr1, iv1, rd1, rv1};
        o2 = {bus2.PHI1_o, bus2.PHI2_o, bus2.SYNC_o, bus2.D_o, bus2.D_oe_o, bus2.CM_ROM_o,
              bus2.CM_RAM_o, instr2, iv2, rd2, rv2};
        chk_cnt++;
        if (o1 !== 27'd0) $display("FAIL async_clear_dut1 got %h expected 0", o1);
        else pass_cnt++;
        chk_cnt++;
        if (o2 !== 27'd0) $display("FAIL async_clear_dut2 got %h expected 0", o2);
        else pass_cnt++;
        bus1.D_i = 4'hE;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        ncount = 0;
        for (int k = 1; k <= 24; k++) begin
            step();
            chk_cnt++;
            if (iv1 !== 1'b0) $display("FAIL no_partial_valid k=%0d got %b expected 0", k, iv1);
            else pass_cnt++;
            if (k == 1) begin
                chk_cnt++;
                if (bus1.SYNC_o !== 1'b1) $display("FAIL restart_sync got %b expected 1", bus1.SYNC_o);
                else pass_cnt++;
            end
            if (k == 5) begin
                chk_cnt++;
                if ({bus1.D_oe_o, bus1.D_o} !== 5'h1C) $display("FAIL restart_a1 got %h expected 1c", {bus1.D_oe_o, bus1.D_o});
                else pass_cnt++;
            end
        end
        $display("test_reset_mid_m1: done");
    endtask

`ifdef MCS4_IO_PHASE_EN
    task automatic test_io_phase();
        logic       exp_oe, exp_rv;
        logic [3:0] exp_d;
        int         rv_seen;
        addr = 12'h000; ram_bank = 4'h0; cm_m2 = 1'b0; io_wr = 1'b0; io_wr_data = 4'h0;
        bus1.D_i = 4'h0;
        rv_seen = 0;
        apply_reset();
        for (int k = 1; k <= 70; k++) begin
            step();
            exp_oe = (k >= 5 && k <= 16) || (k >= 29 && k <= 32) || (k >= 37 && k <= 48);
            exp_d  = (k >= 29 && k <= 32) ? 4'h9 : 4'h0;
            exp_rv = (k == 65);
            if (rv1 === 1'b1) rv_seen++;
            chk_cnt++;
            if (bus1.D_oe_o !== exp_oe) $display("FAIL io_oe k=%0d got %b expected %b", k, bus1.D_oe_o, exp_oe);
            else pass_cnt++;
            chk_cnt++;
            if (bus1.D_o !== exp_d) $display("FAIL io_d_o k=%0d got %h expected %h", k, bus1.D_o, exp_d);
            else pass_cnt++;
            chk_cnt++;
            if (rv1 !== exp_rv) $display("FAIL io_rd_valid k=%0d got %b expected %b", k, rv1, exp_rv);
            else pass_cnt++;
            if (k == 65) begin
                chk_cnt++;
                if (rd1 !== 4'h6) $display("FAIL io_rd_data got %h expected 6", rd1);
                else pass_cnt++;
            end
            if (k == 24) begin io_wr = 1'b1; io_wr_data = 4'h9; end
            if (k == 33) begin io_wr = 1'b0; io_wr_data = 4'h0; end
            if (k == 60) bus1.D_i = 4'h6;
            if (k == 65) bus1.D_i = 4'h0;
        end
        chk_cnt++;
        if (rv_seen != 1) $display("FAIL io_rd_pulses got %0d expected 1", rv_seen);
        else pass_cnt++;
        $display("test_io_phase: rd=%h", rd1);
    endtask
`else
    task automatic test_io_disabled();
        addr = 12'h000; ram_bank = 4'h0; cm_m2 = 1'b0; io_wr = 1'b1; io_wr_data = 4'h9;
        bus1.D_i = 4'h6;
        apply_reset();
        for (int k = 1; k <= 40; k++) begin
            step();
            if (k >= 25 && k <= 36) begin
                chk_cnt++;
                if ({bus1.D_oe_o, bus1.D_o} !== 5'h00) $display("FAIL xphase_idle k=%0d got %h expected 00", k, {bus1.D_oe_o, bus1.D_o});
                else pass_cnt++;
            end
            chk_cnt++;
            if ({rv1, rd1} !== 5'h00) $display("FAIL io_rd_off k=%0d got %h expected 00", k, {rv1, rd1});
            else pass_cnt++;
        end
        io_wr = 1'b0; io_wr_data = 4'h0;
        $display("test_io_disabled: done");
    endtask
`endif

    initial begin
        test_reset();
        test_clkdiv2_timing();
        test_fetch();
        test_cm_lines();
        test_reset_mid_m1();
`ifdef MCS4_IO_PHASE_EN
        test_io_phase();
`else
        test_io_disabled();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/mcs4_bus_master.md
# mcs4_bus_master

CPU-side sequencer for the MCS-4 4-bit multiplexed bus: the initiator that drives the bus cycles to which the ROM and RAM devices respond. It generates the two-phase clock strobes, SYNC, CM-ROM and CM-RAM, and the 8-subcycle instruction cycle (A1 A2 A3 M1 M2 X1 X2 X3). It time-multiplexes a 12-bit fetch address onto the data bus and reassembles the returned 8-bit instruction. It sits between the i4004 core's fetch/execute logic and the bus pins.

## Interface
- CLK_DIV, 1: number of clk_i cycles per tick; must be ≥1. Four ticks make one subcycle.
- clk_i  in  1  main design clock.
- rst_ni  in  1  asynchronous active-low reset.
- PHI1_o  out  1  clock phase 1 strobe.
- PHI2_o  out  1  clock phase 2 strobe.
- SYNC_o  out  1  high throughout X3; marks that the next subcycle is A1.
- D_i  in  4  data bus input.
- D_o  out  4  data bus output value.
- D_oe_o  out  1  data bus output enable.
- CM_ROM_o  out  1  ROM command line.
- CM_RAM_o  out  4  RAM bank command lines.
- addr_i  in  12  fetch address (PC); latched at A1 start.
- ram_bank_i  in  4  CM-RAM select pattern, driven during A3.
- cm_m2_i  in  1  assert CM lines in M2 (I/O or RAM instruction); sampled at M2 start.
- instr_o  out  8  last fetched instruction {OPR, OPA}.
- instr_valid_o  out  1  one-clk pulse when instr_o updates.
- io_wr_i  in  1  drive io_wr_data_i in X2; sampled at X2 start.
- io_wr_data_i  in  4  X2 write nibble.
- io_rd_data_o  out  4  nibble sampled at the end of X2.
- io_rd_valid_o  out  1  one-clk pulse when io_rd_data_o updates.

## Operation
- Subcycle state: one of A1..X3, advancing in order and wrapping X3→A1.
- Tick counter: 0..3 within each subcycle; the counter advances every CLK_DIV clk_i cycles.
- Tick-level strobes:
  - PHI1_o high during tick 0.
  - PHI2_o high during tick 2.
  - PHI1_o and PHI2_o are never high together.
- Address phases:
  - A1: drive addr[3:0], D_oe_o=1.
  - A2: drive addr[7:4], D_oe_o=1.
  - A3: drive addr[11:8], D_oe_o=1.
  - The address is latched at the first clk of A1; changes to addr_i during the rest of the cycle are ignored.
- CM lines:
  - A3: CM_ROM_o=1 and CM_RAM_o=ram_bank_i (latched at A3 start).
  - M2: CM_ROM_o=1 and CM_RAM_o=ram_bank_i only when cm_m2_i=1; otherwise all CM lines are 0.
- Instruction fetch: D_oe_o=0 in M1 and M2.
  - D_i is sampled on the last clk of M1 into OPR and on the last clk of M2 into OPA.
  - instr_o={OPR,OPA} and instr_valid_o pulse on the clk after the M2 sample.
- X phases: X1 and X3 have D_oe_o=0; X2 I/O behaviour is covered under Configuration.
- Reset state: subcycle=X3, tick=0, address latch=0. Every output is 0 (PHI1_o, PHI2_o, SYNC_o, D_o, D_oe_o, CM_ROM_o, CM_RAM_o, instr_o, instr_valid_o, io_rd_data_o, io_rd_valid_o).
- After rst_ni rises, the first subcycle is X3 with SYNC_o=1, followed by A1.

## Timing
- Subcycle length is 4·CLK_DIV clk; instruction cycle length is 32·CLK_DIV clk.
- Fetch latency: instr_valid_o fires 20·CLK_DIV clk after the A1 address latch (end of M2 plus 1 clk).
- All outputs are registered and change only on clk_i edges.
- Reset mid-cycle: all outputs clear asynchronously (D_oe_o drops immediately). No partial instr_valid_o or io_rd_valid_o is emitted afterwards.
- cm_m2_i and io_wr_i asserted outside their sample points have no effect.

## Configuration
- MCS4_IO_PHASE_EN defined:
  - X2 with io_wr_i=1: D_o=io_wr_data_i, D_oe_o=1.
  - X2 with io_wr_i=0: bus released; D_i sampled on the last clk of X2 into io_rd_data_o, with an io_rd_valid_o pulse on the next clk.
- Undefined:
  - X2 is idle with D_oe_o=0.
  - io_rd_data_o=0 and io_rd_valid_o=0 permanently.
  - io_wr_i and io_wr_data_i are ignored.

## Structure
- mcs4_pkg holds:
  - the subcycle enum (A1, A2, A3, M1, M2, X1, X2, X3);
  - TICKS_PER_SUB=4 and SUBS_PER_CYCLE=8;
  - nibble width constants.
- One sub-module, mcs4_phase_gen: the CLK_DIV prescaler, the tick counter and PHI1/PHI2 generation. It outputs tick_en, tick index and sub_end to the sequencer.

## Test plan
- CLK_DIV=1, addr_i=0xA5C, D_i responder returns 0x3 in M1 and 0xE in M2:
  - D_o sequence C,5,A in A1..A3 with D_oe_o=1;
  - instr_o=0x3E, instr_valid_o pulse at clk 20 after A1.
- Release reset with CLK_DIV=2:
  - SYNC_o high for exactly 8 clk (X3), then A1 begins;
  - PHI1_o and PHI2_o each high for 2 clk per subcycle and never overlapping.
- ram_bank_i=0x4 with cm_m2_i=0, then cm_m2_i=1 in the next cycle:
  - CM_ROM_o=1 and CM_RAM_o=0x4 in A3 both cycles;
  - in M2 only on the second cycle.
- With MCS4_IO_PHASE_EN:
  - io_wr_i=1, io_wr_data_i=0x9 → D_o=9 and D_oe_o=1 during X2 only;
  - io_wr_i=0 with D_i=0x6 → io_rd_data_o=6 and one io_rd_valid_o pulse.
- Assert rst_ni low mid-M1:
  - all outputs go 0 immediately;
  - no instr_valid_o pulse;
  - restart from X3 after release.
- Without MCS4_IO_PHASE_EN, io_wr_i=1: D_oe_o=0 throughout X1–X3 and io_rd_valid_o never fires.
